// File: rtl/uart_pkg.sv
// Shared types and constants for the UART boot/debug loader.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LEN   = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    SUM   = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } loader_state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_loader_if.sv
// Loader bus: RX FIFO drain side, memory write side and status pulses.
interface uart_loader_if;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic        timeout;

  // The loader itself
  modport master (
    input  fifo_dout, fifo_empty, mem_ready,
    output fifo_re, mem_addr, mem_wdata, mem_we, busy, done, error, timeout
  );

  // FIFO / memory / status observer side
  modport slave (
    output fifo_dout, fifo_empty, mem_ready,
    input  fifo_re, mem_addr, mem_wdata, mem_we, busy, done, error, timeout
  );
endinterface

// File: rtl/uart_byte_assembler.sv
// Collects four bytes, LSB first, into a 32-bit little-endian word.
// 'word' already includes the byte being loaded this cycle, so the
// caller can capture the full word on the cycle word_complete is high.
module uart_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0]  idx;
  logic [31:0] acc;

  // Merge the incoming byte into its lane of the accumulator
  always_comb begin
    word = acc;
    if (load) word[{idx, 3'b000} +: 8] = din;
  end

  assign word_complete = load && (idx == 2'd3);

  // Byte index and accumulator; index wraps naturally after 4 bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
      acc <= 32'd0;
    end else if (clear) begin
      idx <= 2'd0;
      acc <= 32'd0;
    end else if (load) begin
      idx <= idx + 2'd1;
      acc <= word;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Frame parser: MAGIC, addr[4], len[4], data[4*len], xor checksum.
// Drains the RX FIFO and issues word writes over a valid/ready port.
module uart_loader
  import uart_pkg::*;
#(
  parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  uart_loader_if.master bus
);

  loader_state_t state, state_nxt;

  logic [31:0] addr, wdata, remaining, tmo_cnt;
  logic [7:0]  csum;
  logic        tmo_flag;

  logic        parse, fifo_re, consume, asm_load, asm_clear, tmo_hit;
  logic        mem_we, busy, done, error;
  logic [31:0] word;
  logic        word_complete;

  uart_byte_assembler u_asm (
    .clk           (clk),
    .rst           (rst),
    .load          (asm_load),
    .clear         (asm_clear),
    .din           (bus.fifo_dout),
    .word          (word),
    .word_complete (word_complete)
  );

  // Header/payload states that read the FIFO and are subject to timeout
  assign parse     = (state == ADDR) || (state == LEN) || (state == DATA) || (state == SUM);
  assign consume   = fifo_re;  // fifo_re already implies a non-empty FIFO
  assign asm_load  = consume && ((state == ADDR) || (state == LEN) || (state == DATA));
  assign asm_clear = (state == IDLE) && consume && (bus.fifo_dout == MAGIC);
  // Fires on the edge where the idle counter would reach TIMEOUT_CYCLES-1
  assign tmo_hit   = parse && bus.fifo_empty && (tmo_cnt == TIMEOUT_CYCLES - 32'd2);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    fifo_re   = 1'b0;
    mem_we    = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE: begin
        fifo_re = !bus.fifo_empty;
        if (consume && bus.fifo_dout == MAGIC) state_nxt = ADDR;
      end
      ADDR: begin
        fifo_re = !bus.fifo_empty;
        if (tmo_hit)            state_nxt = ERROR;
        else if (word_complete) state_nxt = LEN;
      end
      LEN: begin
        fifo_re = !bus.fifo_empty;
        if (tmo_hit)            state_nxt = ERROR;
        else if (word_complete) state_nxt = (word == 32'd0) ? SUM : DATA;
      end
      DATA: begin
        fifo_re = !bus.fifo_empty;
        if (tmo_hit)            state_nxt = ERROR;
        else if (word_complete) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (bus.mem_ready) state_nxt = (remaining == 32'd1) ? SUM : DATA;
      end
      SUM: begin
        fifo_re = !bus.fifo_empty;
        if (tmo_hit)      state_nxt = ERROR;
        else if (consume) state_nxt = (bus.fifo_dout == csum) ? DONE : ERROR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERROR: begin
        error     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data/length registers, running checksum and idle timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= 32'd0;
      wdata     <= 32'd0;
      remaining <= 32'd0;
      csum      <= 8'd0;
      tmo_cnt   <= 32'd0;
      tmo_flag  <= 1'b0;
    end else begin
      if (asm_clear) csum <= 8'd0;
      else if (asm_load) csum <= csum ^ bus.fifo_dout;

      if (state == ADDR && word_complete) addr <= {word[31:2], 2'b00};
      if (state == LEN && word_complete) remaining <= word;
      if (state == DATA && word_complete) wdata <= word;

      if (state == WRITE && bus.mem_ready) begin
        addr      <= addr + 32'd4;
        remaining <= remaining - 32'd1;
      end

      if (parse && !consume) tmo_cnt <= tmo_cnt + 32'd1;
      else                   tmo_cnt <= 32'd0;

      tmo_flag <= tmo_hit;
    end
  end

  assign bus.fifo_re   = fifo_re;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_we    = mem_we;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.error     = error;
  assign bus.timeout   = error && tmo_flag;

endmodule
